// File: rtl/sram_controller_pkg.sv
// Shared constants, FSM state encoding and halfword helper for the SRAM controller.
// No logic or latency of its own; it holds definitions only.
package sram_controller_pkg;

  localparam int          WORD_WIDTH      = 32;
  localparam int          SRAM_DATA_WIDTH = 16;
  localparam logic [31:0] MEM_BASE_ADDR   = 32'd1024;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [SRAM_DATA_WIDTH-1:0] half_sel(
    input logic [WORD_WIDTH-1:0] word,
    input logic                  upper
  );
    half_sel = upper ? word[WORD_WIDTH-1:SRAM_DATA_WIDTH] : word[SRAM_DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM access into two 16-bit SRAM phases; ready returns after 2*(WAIT_CYCLES+1)+1 cycles.
// Backpressure: ready drops combinationally while a request is pending, freezing the pipeline until DONE.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_w_en,
  input  logic                       mem_r_en,
  input  logic [WORD_WIDTH-1:0]      alu_res,
  input  logic [WORD_WIDTH-1:0]      Val_Rm,
  output logic [WORD_WIDTH-1:0]      res_data,
  output logic                       ready,
  output logic [SRAM_ADDR_W-1:0]     sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);

  if (WAIT_CYCLES < 1) begin : g_wait_chk
    $error("sram_controller: WAIT_CYCLES must be >= 1");
  end

  localparam int                CNT_W      = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WAIT_CYCLES);
  localparam logic [31:0]       BASE_WORDS = MEM_BASE_ADDR >> 2;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         wr_q, wr_d;
  logic [SRAM_DATA_WIDTH-1:0]   lo_q, hi_q;

  logic                         req;
  logic                         phase_last;
  logic                         in_phase;
  logic                         upper;
  logic [SRAM_ADDR_W-2:0]       word_idx;

  assign req        = mem_w_en | mem_r_en;
  assign phase_last = (cnt_q == CNT_LAST);
  assign in_phase   = (state_q == S_LOW) || (state_q == S_HIGH);
  assign upper      = (state_q == S_HIGH);

  // Subtracting the base only touches address bits that survive into the halfword index,
  // so the word index is computed directly at SRAM width (wraps modulo 2^SRAM_ADDR_W).
  assign word_idx = alu_res[SRAM_ADDR_W:2] - BASE_WORDS[SRAM_ADDR_W-2:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LOW;
          cnt_d   = '0;
          wr_d    = mem_w_en;
        end
      end
      S_LOW: begin
        if (phase_last) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The operation is latched at access start so a dropped request still finishes as the same kind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (!wr_q && phase_last) begin
      if (state_q == S_LOW) begin
        lo_q <= sram_rdata;
      end else if (state_q == S_HIGH) begin
        hi_q <= sram_rdata;
      end
    end
  end

  always_comb begin
    ready      = ~req | (state_q == S_DONE);
    res_data   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    if (in_phase) begin
      sram_addr = {word_idx, upper};
      if (wr_q) begin
        sram_wdata = half_sel(Val_Rm, upper);
        // Write strobe rises on the last cycle of the phase so data/address are held past it.
        sram_we_n  = phase_last;
      end else begin
        sram_oe_n = 1'b0;
      end
    end else if ((state_q == S_DONE) && !wr_q) begin
      res_data = {hi_q, lo_q};
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM model, access-timeline reference model and directed scenarios.
module tb_sram_controller;

  localparam int W = 1;
  localparam int P = W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_w_en, mem_r_en;
  logic [31:0] alu_res, Val_Rm;
  logic [31:0] res_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_we_n, sram_oe_n;

  sram_controller #(.WAIT_CYCLES(W), .SRAM_ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .alu_res(alu_res), .Val_Rm(Val_Rm), .res_data(res_data), .ready(ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  logic [15:0] sram_mem [0:255];
  logic [15:0] ref_mem  [0:255];

  assign sram_rdata = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[7:0]];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_wdata;

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;
  bit chk_en = 1'b0;
  logic [31:0] last_res;

  logic        exp_ready, exp_we_n, exp_oe_n;
  logic [17:0] exp_addr;
  logic [15:0] exp_wdata;
  logic [31:0] exp_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for cycle k of an access (k=0 is the request cycle in IDLE).
  task automatic set_model(input bit wr, input bit rd, input int k,
                           input logic [31:0] a, input logic [31:0] d);
    int unsigned b;
    bit hi;
    int j;
    b = (((a & 32'hFFFF_FFFC) - 32'd1024) >> 1) % (32'd1 << 18);
    exp_ready = !(wr || rd);
    exp_we_n  = 1'b1;
    exp_oe_n  = 1'b1;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_res   = '0;
    if (wr || rd) begin
      if (k >= 1 && k <= 2 * P) begin
        hi = (k > P);
        j  = hi ? k - 1 - P : k - 1;
        exp_addr = 18'(b + (hi ? 1 : 0));
        if (wr) begin
          exp_wdata = hi ? d[31:16] : d[15:0];
          exp_we_n  = (j == W);
        end else begin
          exp_oe_n = 1'b0;
        end
      end else if (k == 2 * P + 1) begin
        exp_ready = 1'b1;
        if (!wr) exp_res = {ref_mem[(b + 1) & 255], ref_mem[b & 255]};
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",      32'(ready),      32'(exp_ready));
      check("sram_we_n",  32'(sram_we_n),  32'(exp_we_n));
      check("sram_oe_n",  32'(sram_oe_n),  32'(exp_oe_n));
      check("sram_addr",  32'(sram_addr),  32'(exp_addr));
      check("sram_wdata", 32'(sram_wdata), 32'(exp_wdata));
      check("res_data",   res_data,        exp_res);
      if (ready === 1'b0) stall_cnt++;
    end
  end

  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input int last_k);
    int unsigned b;
    b = (((a & 32'hFFFF_FFFC) - 32'd1024) >> 1) % (32'd1 << 18);
    for (int k = 0; k <= last_k; k++) begin
      @(posedge clk); #2;
      mem_w_en = wr; mem_r_en = rd; alu_res = a; Val_Rm = d;
      set_model(wr, rd, k, a, d);
    end
    if (wr && last_k == 2 * P + 1) begin
      ref_mem[b & 255]       = d[15:0];
      ref_mem[(b + 1) & 255] = d[31:16];
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #2;
    mem_w_en = 1'b0; mem_r_en = 1'b0;
    set_model(1'b0, 1'b0, 0, 32'h0, 32'h0);
  endtask

  task automatic sample_res();
    @(negedge clk); #1;
    last_res = res_data;
  endtask

  initial begin
    rst = 1'b1; mem_w_en = 1'b0; mem_r_en = 1'b0; alu_res = '0; Val_Rm = '0;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 16'h0000;
      ref_mem[i]  = 16'h0000;
    end
    #12;
    check("rst_ready",    32'(ready),     32'd1);
    check("rst_we_n",     32'(sram_we_n), 32'd1);
    check("rst_oe_n",     32'(sram_oe_n), 32'd1);
    check("rst_res_data", res_data,       32'd0);
    @(negedge clk); rst = 1'b0;
    set_model(1'b0, 1'b0, 0, 32'h0, 32'h0);
    chk_en = 1'b1;

    // Write 0x12345678 at 1028: halfwords 2 and 3, five stall cycles.
    go_idle();
    @(negedge clk); #1; stall_cnt = 0;
    access(1'b1, 1'b0, 32'd1028, 32'h1234_5678, 2 * P + 1);
    go_idle();
    @(negedge clk); #1;
    check("wr_stall_cycles", 32'(stall_cnt), 32'd5);
    check("wr_sram_hw2", 32'(sram_mem[2]), 32'h5678);
    check("wr_sram_hw3", 32'(sram_mem[3]), 32'h1234);

    // Read back at 1028, then at 1030 (low address bits ignored).
    access(1'b0, 1'b1, 32'd1028, 32'h0, 2 * P + 1);
    sample_res();
    check("rd_1028", last_res, 32'h1234_5678);
    go_idle();
    @(negedge clk); #1;
    check("rd_after_done", res_data, 32'd0);
    access(1'b0, 1'b1, 32'd1030, 32'h0, 2 * P + 1);
    sample_res();
    check("rd_1030", last_res, 32'h1234_5678);
    go_idle();

    // Both enables: treated as a write only.
    access(1'b1, 1'b1, 32'd1032, 32'hCAFE_BABE, 2 * P + 1);
    go_idle();
    access(1'b0, 1'b1, 32'd1032, 32'h0, 2 * P + 1);
    sample_res();
    check("rd_1032", last_res, 32'hCAFE_BABE);
    go_idle();

    // Reset during the HIGH phase of a write to 1036 (halfwords 6 and 7).
    sram_mem[7] = 16'hAAAA;
    ref_mem[7]  = 16'hAAAA;
    access(1'b1, 1'b0, 32'd1036, 32'h1111_2222, P + 1);
    @(negedge clk); #1;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_oe_n", 32'(sram_oe_n), 32'd1);
    mem_w_en = 1'b0; mem_r_en = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    check("abort_ready", 32'(ready),     32'd1);
    check("abort_addr",  32'(sram_addr), 32'd0);
    @(negedge clk); #1;
    check("abort_hw7_kept", 32'(sram_mem[7]), 32'hAAAA);
    check("abort_hw6_low",  32'(sram_mem[6]), 32'h2222);
    set_model(1'b0, 1'b0, 0, 32'h0, 32'h0);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
